// File: rtl/dualshock_pkg.sv
// Shared constants, FSM state type and response-byte lookup for the
// DualShock-style controller responder.
package dualshock_pkg;

  localparam logic [7:0] HDR      = 8'h01;
  localparam logic [7:0] CMD_POLL = 8'h42;
  localparam logic [7:0] CMD_CFG  = 8'h43;
  localparam logic [7:0] ID_DIG   = 8'h41;
  localparam logic [7:0] ID_ANA   = 8'h73;
  localparam logic [7:0] READY    = 8'h5A;

  localparam logic [3:0] LAST_DIG = 4'd4;
  localparam logic [3:0] LAST_ANA = 4'd8;

  typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK, IGNORE} ds_state_e;

  // Pad state frozen at the start of a frame so the reply is self-consistent.
  typedef struct packed {
    logic [15:0] btn;
    logic [31:0] axes;   // {ly, lx, ry, rx}
    logic        analog;
  } pad_snap_t;

  function automatic logic [7:0] resp_byte(input logic [3:0] idx, input pad_snap_t s);
    case (idx)
      4'd1:    return s.analog ? ID_ANA : ID_DIG;
      4'd2:    return READY;
      4'd3:    return s.btn[7:0];
      4'd4:    return s.btn[15:8];
      4'd5:    return s.axes[7:0];
      4'd6:    return s.axes[15:8];
      4'd7:    return s.axes[23:16];
      4'd8:    return s.axes[31:24];
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/dualshock_responder_if.sv
// Controller-port bus between a console host and the pad.
//   ps_clk  host SPI clock, idle high      ps_sel  select, active low
//   ps_cmd  host command bit               ps_dat  pad response bit
//   ps_ack  pad acknowledge, active low
interface dualshock_responder_if;
  logic ps_clk;
  logic ps_sel;
  logic ps_cmd;
  logic ps_dat;
  logic ps_ack;

  modport master (output ps_clk, ps_sel, ps_cmd, input  ps_dat, ps_ack);
  modport slave  (input  ps_clk, ps_sel, ps_cmd, output ps_dat, ps_ack);
endinterface

// File: rtl/ds_sync_edge.sv
// Two-flop synchronizer with rise/fall detect on the synchronized copy.
//   clk, resetn  system clock, async active-low reset
//   d            asynchronous input
//   q            synchronized level
//   rise, fall   one-clock edge strobes
// Flops reset to the idle level (1). Edges are masked until the pipeline
// holds only post-reset samples, so a line already low when reset releases
// does not look like a fresh falling edge.
module ds_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic       prev;
  logic [2:0] vld_pipe;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync     <= 2'b11;
      prev     <= 1'b1;
      vld_pipe <= '0;
    end else begin
      sync     <= {sync[0], d};
      prev     <= sync[1];
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end

  assign q    = sync[1];
  assign rise = vld_pipe[2] &  q & ~prev;
  assign fall = vld_pipe[2] & ~q &  prev;
endmodule

// File: rtl/dualshock_responder.sv
// Controller-side responder for a DualShock-style poll protocol.
//   clk, resetn       system clock, async active-low reset
//   ps (slave)        host bus: ps_clk/ps_sel/ps_cmd in, ps_dat/ps_ack out
//   btn[15:0]         active-low buttons (byte3=[7:0], byte4=[15:8])
//   axes[31:0]        {ly, lx, ry, rx}
//   analog_mode       1 = analog reply (ID 0x73, 9 bytes)
//   vib_small/large   motor bytes of the last completed 0x42 frame
//   frame_done        one-clock pulse at ps_sel rise after a full frame
//   hdr_err           one-clock pulse on bad header / command byte
module dualshock_responder
  import dualshock_pkg::*;
#(
  parameter int FREQ          = 50_000_000,
  parameter int ACK_DELAY_CYC = FREQ / 100_000,
  parameter int ACK_WIDTH_CYC = FREQ / 250_000
) (
  input  logic        clk,
  input  logic        resetn,
  dualshock_responder_if.slave ps,
  input  logic [15:0] btn,
  input  logic [31:0] axes,
  input  logic        analog_mode,
  output logic [7:0]  vib_small,
  output logic [7:0]  vib_large,
  output logic        frame_done,
  output logic        hdr_err
);
  localparam int CNT_MAX = (ACK_DELAY_CYC > ACK_WIDTH_CYC) ?
                           ((ACK_DELAY_CYC > 1) ? ACK_DELAY_CYC : 1) :
                           ((ACK_WIDTH_CYC > 1) ? ACK_WIDTH_CYC : 1);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DLY_END = (ACK_DELAY_CYC > 0) ? ACK_DELAY_CYC - 1 : 0;
  localparam int WID_END = (ACK_WIDTH_CYC > 0) ? ACK_WIDTH_CYC - 1 : 0;

  // Lane 0 = ps_clk, 1 = ps_sel, 2 = ps_cmd.
  logic [2:0] raw, sq, sr, sf;
  assign raw = {ps.ps_cmd, ps.ps_sel, ps.ps_clk};

  ds_sync_edge u_sync [2:0] (
    .clk    (clk),
    .resetn (resetn),
    .d      (raw),
    .q      (sq),
    .rise   (sr),
    .fall   (sf)
  );

  logic clk_rise, clk_fall, sel_rise, sel_fall, cmd_s;
  assign clk_rise = sr[0];
  assign clk_fall = sf[0];
  assign sel_rise = sr[1];
  assign sel_fall = sf[1];
  assign cmd_s    = sq[2];

  logic unused;
  assign unused = ^{sq[1:0], sr[2], sf[2]};

  ds_state_e   state;
  pad_snap_t   snap;
  logic [3:0]  idx;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx;
  logic [6:0]  rx;
  logic [CW-1:0] cnt;
  logic        poll;      // frame command is 0x42
  logic        complete;  // last byte exchanged, waiting for ps_sel rise
  logic [7:0]  mot3, mot4;

  logic [7:0] rx_next;
  logic [3:0] last_idx;
  logic       bad_byte;
  assign rx_next  = {cmd_s, rx};
  assign last_idx = snap.analog ? LAST_ANA : LAST_DIG;
  assign bad_byte = (idx == 4'd0 && rx_next != HDR) ||
                    (idx == 4'd1 && rx_next != CMD_POLL && rx_next != CMD_CFG);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      ps.ps_dat  <= 1'b1;
      ps.ps_ack  <= 1'b1;
      vib_small  <= '0;
      vib_large  <= '0;
      frame_done <= 1'b0;
      hdr_err    <= 1'b0;
      snap       <= '0;
      idx        <= '0;
      bit_cnt    <= '0;
      tx         <= 8'hFF;
      rx         <= '0;
      cnt        <= '0;
      poll       <= 1'b0;
      complete   <= 1'b0;
      mot3       <= '0;
      mot4       <= '0;
    end else begin
      frame_done <= 1'b0;
      hdr_err    <= 1'b0;
      // Deselect wins over any clock edge in the same cycle.
      if (state != IDLE && sel_rise) begin
        if (state == SHIFT && complete) begin
          frame_done <= 1'b1;
          if (poll) begin
            vib_small <= mot3;
            vib_large <= mot4;
          end
        end
        state     <= IDLE;
        ps.ps_dat <= 1'b1;
        ps.ps_ack <= 1'b1;
        complete  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (sel_fall) begin
            snap      <= '{btn: btn, axes: axes, analog: analog_mode};
            idx       <= '0;
            bit_cnt   <= '0;
            tx        <= 8'hFF;
            complete  <= 1'b0;
            poll      <= 1'b0;
            ps.ps_dat <= 1'b1;
            ps.ps_ack <= 1'b1;
            state     <= SHIFT;
          end
          SHIFT: if (!complete) begin
            if (clk_fall) begin
              ps.ps_dat <= tx[bit_cnt];
            end else if (clk_rise) begin
              rx      <= rx_next[7:1];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ps.ps_dat <= 1'b1;   // line idles high until the next byte's first fall
                if (bad_byte) begin
                  hdr_err <= 1'b1;
                  state   <= IGNORE;
                end else begin
                  if (idx == 4'd1) poll <= (rx_next == CMD_POLL);
                  if (idx == 4'd3) mot3 <= rx_next;
                  if (idx == 4'd4) mot4 <= rx_next;
                  if (idx == last_idx) begin
                    complete <= 1'b1;
                  end else begin
                    idx   <= idx + 4'd1;
                    tx    <= resp_byte(idx + 4'd1, snap);
                    cnt   <= '0;
                    state <= ACK_WAIT;
                  end
                end
              end
            end
          end
          ACK_WAIT: begin
            if (cnt == CW'(DLY_END)) begin
              cnt       <= '0;
              ps.ps_ack <= 1'b0;
              state     <= ACK;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ACK: begin
            if (cnt == CW'(WID_END)) begin
              cnt       <= '0;
              ps.ps_ack <= 1'b1;
              state     <= SHIFT;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
